rvecc_scrub_pipe: RTL and testbench

RVECC_SCRUB_PIPE -- requirements
Module: rvecc_scrub_pipe

---
 rtl/rvecc_scrub_pipe.sv | 190 +++++++++++++++++++
 tb/tb_rvecc_scrub_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvecc_scrub_pipe.sv
// rvecc_scrub_pipe: two-stage SEC-DED scrub pipeline with saturating error counters.
// Optional first-error syndrome log is built only when RV_ECC_SCRUB_LOG_EN is defined.
module rvecc_scrub_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  // smallest P with 2^P >= DATA_WIDTH+P+1 across the legal 8..64 range
  localparam int unsigned P = (DATA_WIDTH <= 11) ? 4 : (DATA_WIDTH <= 26) ? 5 :
                              (DATA_WIDTH <= 57) ? 6 : 7,
  localparam int unsigned ECC_WIDTH = P + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ECC_WIDTH-1:0]  in_ecc,
  input  logic                  sed_ded,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ECC_WIDTH-1:0]  out_ecc,
  output logic                  out_sb_err,
  output logic                  out_db_err,
  output logic [CNT_WIDTH-1:0]  sb_cnt,
  output logic [CNT_WIDTH-1:0]  db_cnt,
  input  logic                  cnt_clr,
  output logic                  err_log_valid,
  output logic [ECC_WIDTH-1:0]  err_log_syndrome,
  input  logic                  err_log_clr
);

  localparam int unsigned N = DATA_WIDTH + P;

  // Hamming check bits: every set data bit contributes its codeword position.
  function automatic logic [P-1:0] ham_bits(input logic [DATA_WIDTH-1:0] d);
    logic [P-1:0]          h;
    logic [DATA_WIDTH-1:0] ds;
    int unsigned           di;
    h  = '0;
    di = 0;
    for (int unsigned pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        ds = d >> di;
        if (ds[0]) h = h ^ P'(pos);
        di++;
      end
    end
    return h;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] flip_at(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [P-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    int unsigned           di;
    r  = d;
    di = 0;
    for (int unsigned pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (pos == 32'(s)) r = r ^ (DATA_WIDTH'(1) << di);
        di++;
      end
    end
    return r;
  endfunction

  logic                  s1_valid_q, s1_ovr_q, s1_sed_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [P-1:0]          s1_syn_q;
  logic                  out_valid_q, out_sb_q, out_db_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ECC_WIDTH-1:0]  out_ecc_q;
  logic [CNT_WIDTH-1:0]  sb_cnt_q, db_cnt_q;

  logic                  s2_adv, out_fire;
  logic [P-1:0]          syn_d;
  logic                  ovr_d;
  logic                  sb_d, db_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [P-1:0]          hb_d;
  logic [ECC_WIDTH-1:0]  ecc_d;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign out_fire = out_valid_q && out_ready;

  assign syn_d = ham_bits(in_data) ^ in_ecc[P-1:0];
  assign ovr_d = !sed_ded && (^{in_data, in_ecc});

  always_comb begin
    sb_d = 1'b0;
    db_d = 1'b0;
    if (s1_sed_q) begin
      db_d = (s1_syn_q != '0);
    end else if (s1_ovr_q) begin
      if (32'(s1_syn_q) <= N) sb_d = 1'b1;
      else                    db_d = 1'b1;
    end else begin
      db_d = (s1_syn_q != '0);
    end
    // check-bit flips need no data change; out_ecc is regenerated below
    data_d = sb_d ? flip_at(s1_data_q, s1_syn_q) : s1_data_q;
    hb_d   = ham_bits(data_d);
    ecc_d  = {(^data_d) ^ (^hb_d), hb_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_syn_q    <= '0;
      s1_ovr_q    <= 1'b0;
      s1_sed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ecc_q   <= '0;
      out_sb_q    <= 1'b0;
      out_db_q    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_data_q <= in_data;
          s1_syn_q  <= syn_d;
          s1_ovr_q  <= ovr_d;
          s1_sed_q  <= sed_ded;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= data_d;
          out_ecc_q  <= ecc_d;
          out_sb_q   <= sb_d;
          out_db_q   <= db_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sb_cnt_q <= '0;
      db_cnt_q <= '0;
    end else if (out_fire) begin
      if (out_sb_q && (sb_cnt_q != '1)) sb_cnt_q <= sb_cnt_q + CNT_WIDTH'(1);
      if (out_db_q && (db_cnt_q != '1)) db_cnt_q <= db_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ecc    = out_ecc_q;
  assign out_sb_err = out_sb_q;
  assign out_db_err = out_db_q;
  assign sb_cnt     = sb_cnt_q;
  assign db_cnt     = db_cnt_q;

`ifdef RV_ECC_SCRUB_LOG_EN
  logic [ECC_WIDTH-1:0] out_syn_q, log_syn_q;
  logic                 log_valid_q, log_cap;

  // a clear coinciding with a new error re-arms and captures in the same cycle
  assign log_cap = out_fire && (out_sb_q || out_db_q) && (!log_valid_q || err_log_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_syn_q   <= '0;
      log_syn_q   <= '0;
      log_valid_q <= 1'b0;
    end else begin
      if (s2_adv && s1_valid_q) out_syn_q <= {s1_ovr_q, s1_syn_q};
      if (log_cap) begin
        log_valid_q <= 1'b1;
        log_syn_q   <= out_syn_q;
      end else if (err_log_clr) begin
        log_valid_q <= 1'b0;
      end
    end
  end

  assign err_log_valid    = log_valid_q;
  assign err_log_syndrome = log_syn_q;
`else
  logic unused_log_clr;
  assign unused_log_clr   = err_log_clr;
  assign err_log_valid    = 1'b0;
  assign err_log_syndrome = '0;
`endif

endmodule

// File: tb/tb_rvecc_scrub_pipe.sv
// Self-checking bench for rvecc_scrub_pipe: directed cases plus randomized traffic
// against a position-list SEC-DED model and an in-order beat queue.
module tb_rvecc_scrub_pipe;
  localparam int unsigned DW   = 32;
  localparam int unsigned EW   = 7;
  localparam int unsigned NPOS = 38;
  localparam int unsigned CMAX = 3;
`ifdef RV_ECC_SCRUB_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic          clk, rst;
  logic          in_valid, in_ready, sed_ded;
  logic [DW-1:0] in_data;
  logic [EW-1:0] in_ecc;
  logic          out_valid, out_ready, out_sb_err, out_db_err;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_ecc;
  logic [1:0]    sb_cnt, db_cnt;
  logic          cnt_clr, err_log_valid, err_log_clr;
  logic [EW-1:0] err_log_syndrome;

  rvecc_scrub_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ecc(in_ecc),
    .sed_ded(sed_ded),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ecc(out_ecc),
    .out_sb_err(out_sb_err), .out_db_err(out_db_err),
    .sb_cnt(sb_cnt), .db_cnt(db_cnt), .cnt_clr(cnt_clr),
    .err_log_valid(err_log_valid), .err_log_syndrome(err_log_syndrome),
    .err_log_clr(err_log_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [EW-1:0] ecc;
    logic          sb;
    logic          db;
    logic [EW-1:0] syn;
    int unsigned   acc;
  } beat_t;

  beat_t       q[$];
  int unsigned dpos[DW];
  int          checks, failures;
  int unsigned ecnt;
  int unsigned m_sb, m_db;
  bit          m_lv;
  logic [EW-1:0] m_ls;
  bit          accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] enc(input logic [DW-1:0] d);
    int unsigned h;
    h = 0;
    for (int i = 0; i < DW; i++) if (d[i]) h ^= dpos[i];
    return {1'(($countones(d) + $countones(h)) % 2), h[5:0]};
  endfunction

  function automatic beat_t model(input logic [DW-1:0] d, input logic [EW-1:0] e, input bit sed);
    beat_t       r;
    int unsigned s;
    bit          o;
    logic [DW-1:0] c;
    s = 0;
    for (int i = 0; i < DW; i++) if (d[i]) s ^= dpos[i];
    for (int k = 0; k < 6; k++) if (e[k]) s ^= (1 << k);
    o = (($countones(d) + $countones(e)) % 2) == 1;
    if (sed) o = 1'b0;
    r.sb = 1'b0;
    r.db = 1'b0;
    if (sed)      r.db = (s != 0);
    else if (o)   begin if (s <= NPOS) r.sb = 1'b1; else r.db = 1'b1; end
    else          r.db = (s != 0);
    c = d;
    if (r.sb) for (int i = 0; i < DW; i++) if (dpos[i] == s) c[i] = ~c[i];
    r.data = c;
    r.ecc  = enc(c);
    r.syn  = {o, s[5:0]};
    r.acc  = 0;
    return r;
  endfunction

  task automatic cycle();
    logic  exp_ov, exp_ir;
    beat_t b;
    @(negedge clk);
    exp_ir = (q.size() < 2) || out_ready;
    exp_ov = (q.size() > 0) && (ecnt >= q[0].acc + 1);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_data", out_data, q[0].data);
      chk("out_ecc", out_ecc, q[0].ecc);
      chk("out_sb_err", out_sb_err, q[0].sb);
      chk("out_db_err", out_db_err, q[0].db);
    end
    if (exp_ov && out_ready) begin
      b = q.pop_front();
      if (b.sb && m_sb < CMAX) m_sb++;
      if (b.db && m_db < CMAX) m_db++;
      if ((b.sb || b.db) && (!m_lv || err_log_clr)) begin
        m_lv = 1'b1;
        m_ls = b.syn;
      end else if (err_log_clr) m_lv = 1'b0;
    end else if (err_log_clr) m_lv = 1'b0;
    if (cnt_clr) begin m_sb = 0; m_db = 0; end
    accepted = in_valid && in_ready;
    if (accepted) begin
      b = model(in_data, in_ecc, sed_ded);
      b.acc = ecnt + 1;
      q.push_back(b);
    end
    @(posedge clk);
    ecnt++;
    #1;
    chk("sb_cnt", sb_cnt, m_sb);
    chk("db_cnt", db_cnt, m_db);
    chk("err_log_valid", err_log_valid, LOG_EN ? m_lv : 1'b0);
    chk("err_log_syndrome", err_log_syndrome, LOG_EN ? m_ls : 7'h00);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [EW-1:0] e, input bit s);
    in_valid = 1'b1; in_data = d; in_ecc = e; sed_ded = s;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (accepted) break;
    end
    in_valid = 1'b0;
    chk("send_accepted", accepted, 1'b1);
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12 && q.size() > 0; i++) cycle();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; err_log_clr = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); m_sb = 0; m_db = 0; m_lv = 1'b0; m_ls = '0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ecc", out_ecc, 0);
    chk("rst_sb_err", out_sb_err, 1'b0);
    chk("rst_db_err", out_db_err, 1'b0);
    chk("rst_sb_cnt", sb_cnt, 0);
    chk("rst_db_cnt", db_cnt, 0);
    chk("rst_log_valid", err_log_valid, 1'b0);
    chk("rst_log_syn", err_log_syndrome, 0);
  endtask

  task automatic gen_beat(output logic [DW-1:0] d, output logic [EW-1:0] e, output bit s);
    int unsigned kind, b1, b2;
    d = $urandom;
    e = enc(d);
    kind = $urandom_range(0, 4);
    b1 = $urandom_range(0, NPOS);
    b2 = (b1 + 1 + $urandom_range(0, NPOS - 1)) % (NPOS + 1);
    if (kind == 1 || kind == 3) begin
      if (b1 < DW) d[b1] = ~d[b1]; else e[b1 - DW] = ~e[b1 - DW];
    end
    if (kind == 3) begin
      if (b2 < DW) d[b2] = ~d[b2]; else e[b2 - DW] = ~e[b2 - DW];
    end
    if (kind == 4) e = EW'($urandom);
    s = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    int unsigned   n;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    bit            s;
    checks = 0; failures = 0; ecnt = 0; n = 0;
    for (int unsigned pos = 1; pos <= NPOS; pos++)
      if ((pos & (pos - 1)) != 0) begin dpos[n] = pos; n++; end
    in_valid = 1'b0; in_data = '0; in_ecc = '0; sed_ded = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0; err_log_clr = 1'b0; rst = 1'b1;
    do_reset();

    // clean zero word, two-cycle latency
    send(32'h0, 7'h00, 1'b0);
    cycle();
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_out_data", out_data, 0);
    chk("lat_flags", {out_sb_err, out_db_err}, 2'b00);
    drain();

    // single data-bit error at position 3
    send(32'h1, 7'h00, 1'b0);
    drain();
    chk("sb1_cnt", sb_cnt, 1);
    chk("sb1_log_syn", err_log_syndrome, LOG_EN ? 7'h43 : 7'h00);

    // double error, data passed through
    send(32'h3, 7'h00, 1'b0);
    drain();
    chk("db1_cnt", db_cnt, 1);
    chk("db1_log_keeps_first", err_log_syndrome, LOG_EN ? 7'h43 : 7'h00);

    // overall-parity-only error, then the same beat in detect-only mode
    send(32'h0, 7'h40, 1'b0);
    send(32'h0, 7'h40, 1'b1);
    drain();

    // backpressure: two beats held, third waits, then in-order drain
    out_ready = 1'b0;
    send(32'hA5A5_0001, 7'h00, 1'b0);
    send(32'h0000_0003, 7'h00, 1'b0);
    in_valid = 1'b1; in_data = 32'h1234_5678; in_ecc = enc(32'h1234_5678); sed_ded = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", in_ready, 1'b0);
      cycle();
    end
    out_ready = 1'b1;
    send(32'h1234_5678, enc(32'h1234_5678), 1'b0);
    drain();

    // counter saturation at 2 bits and clear priority
    do_reset();
    for (int i = 0; i < 5; i++) send(32'h1 << i, 7'h00, 1'b0);
    drain();
    chk("sat_sb_cnt", sb_cnt, 3);
    send(32'h1, 7'h00, 1'b0);
    cycle();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("clr_sb_cnt", sb_cnt, 0);
    drain();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      gen_beat(d, e, s);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = d; in_ecc = e; sed_ded = s;
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 29) == 0);
      err_log_clr = ($urandom_range(0, 9) == 0);
      cycle();
    end
    cnt_clr = 1'b0; err_log_clr = 1'b0;
    drain();

    // reset with beats in flight discards them
    out_ready = 1'b0;
    send(32'h1, 7'h00, 1'b0);
    send(32'h2, 7'h00, 1'b0);
    do_reset();
    cycle();
    chk("post_rst_empty", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
